// File: rtl/sys_timer_if.sv
// Bus port of the machine timer: per-device request signals in, read data and responses out.
interface sys_timer_if;
   logic [31:0] rw_address_i;
   logic [31:0] read_data_o;
   logic        read_request_i;
   logic        read_response_o;
   logic [31:0] write_data_i;
   logic [3:0]  write_strobe_i;
   logic        write_request_i;
   logic        write_response_o;
   logic        irq_o;

   // Bus side drives requests, samples responses
   modport master (
      output rw_address_i, read_request_i, write_data_i, write_strobe_i, write_request_i,
      input  read_data_o, read_response_o, write_response_o, irq_o
   );

   // Timer side
   modport slave (
      input  rw_address_i, read_request_i, write_data_i, write_strobe_i, write_request_i,
      output read_data_o, read_response_o, write_response_o, irq_o
   );
endinterface

// File: rtl/sys_timer.sv
// 64-bit memory-mapped machine timer with prescaler and level interrupt.
module sys_timer #(
   parameter int unsigned PRESCALE = 1
) (
   input logic       clock_i,
   input logic       reset_i,
   sys_timer_if.slave bus
);

   localparam logic [2:0] ADDR_CTRL     = 3'd0;
   localparam logic [2:0] ADDR_MTIME_LO = 3'd1;
   localparam logic [2:0] ADDR_MTIME_HI = 3'd2;
   localparam logic [2:0] ADDR_CMP_LO   = 3'd3;
   localparam logic [2:0] ADDR_CMP_HI   = 3'd4;

   localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);

   logic        en_q, en_d;
   logic [15:0] cnt_q, cnt_d;
   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rresp_q, wresp_q, irq_q;

   logic [2:0]  sel;
   logic [31:0] wmask;
   logic [31:0] rd_val;
   logic        tick;
   logic        unused_addr;

   assign sel         = bus.rw_address_i[4:2];
   assign unused_addr = ^{bus.rw_address_i[31:5], bus.rw_address_i[1:0]};
   assign wmask       = {{8{bus.write_strobe_i[3]}}, {8{bus.write_strobe_i[2]}},
                         {8{bus.write_strobe_i[1]}}, {8{bus.write_strobe_i[0]}}};
   assign tick        = en_q && (cnt_q == PRESCALE_MAX);

   // Byte-lane merge of write data over an existing 32-bit word
   function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                         input logic [31:0] mask);
      return (old_val & ~mask) | (new_val & mask);
   endfunction

   // Register read mux, reflecting the value before this edge's updates
   always_comb begin
      rd_val = 32'd0;
      case (sel)
         ADDR_CTRL:     rd_val = {31'd0, en_q};
         ADDR_MTIME_LO: rd_val = mtime_q[31:0];
         ADDR_MTIME_HI: rd_val = mtime_q[63:32];
         ADDR_CMP_LO:   rd_val = mtimecmp_q[31:0];
         ADDR_CMP_HI:   rd_val = mtimecmp_q[63:32];
         default:       rd_val = 32'd0;
      endcase
   end

   // Next-state: prescaler, increment, then software writes override
   always_comb begin
      en_d       = en_q;
      cnt_d      = cnt_q;
      mtime_d    = mtime_q;
      mtimecmp_d = mtimecmp_q;

      if (en_q) begin
         cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
         if (tick) mtime_d = mtime_q + 64'd1;
      end

      if (bus.write_request_i) begin
         case (sel)
            ADDR_CTRL: begin
               if (bus.write_strobe_i[0]) en_d = bus.write_data_i[0];
               cnt_d = 16'd0;
            end
            // A write to either half replaces the whole value, dropping any increment
            ADDR_MTIME_LO: mtime_d = {mtime_q[63:32],
                                      merge(mtime_q[31:0], bus.write_data_i, wmask)};
            ADDR_MTIME_HI: mtime_d = {merge(mtime_q[63:32], bus.write_data_i, wmask),
                                      mtime_q[31:0]};
            ADDR_CMP_LO:   mtimecmp_d = {mtimecmp_q[63:32],
                                         merge(mtimecmp_q[31:0], bus.write_data_i, wmask)};
            ADDR_CMP_HI:   mtimecmp_d = {merge(mtimecmp_q[63:32], bus.write_data_i, wmask),
                                         mtimecmp_q[31:0]};
            default: ;
         endcase
      end

      rdata_d = bus.read_request_i ? rd_val : 32'd0;
   end

   // State and registered responses, synchronous active-low reset
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         en_q       <= 1'b0;
         cnt_q      <= 16'd0;
         mtime_q    <= 64'd0;
         mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
         rdata_q    <= 32'd0;
         rresp_q    <= 1'b0;
         wresp_q    <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         en_q       <= en_d;
         cnt_q      <= cnt_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         rdata_q    <= rdata_d;
         rresp_q    <= bus.read_request_i;
         wresp_q    <= bus.write_request_i;
         // Compare of the held register values, so irq lags mtime/mtimecmp by a cycle
         irq_q      <= en_q && (mtime_q >= mtimecmp_q);
      end
   end

   assign bus.read_data_o      = rdata_q;
   assign bus.read_response_o  = rresp_q;
   assign bus.write_response_o = wresp_q;
   assign bus.irq_o            = irq_q;

endmodule

// File: tb/tb_sys_timer.sv
// Self-checking bench: two timers (PRESCALE 4 and 1) share one stimulus stream.
module tb_sys_timer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [3:0]  strb = 4'd0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;

   int n_checks = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   sys_timer_if bus4 ();
   sys_timer_if bus1 ();

   assign bus4.rw_address_i = addr;
   assign bus4.read_request_i = rd;
   assign bus4.write_data_i = wdata;
   assign bus4.write_strobe_i = strb;
   assign bus4.write_request_i = wr;
   assign bus1.rw_address_i = addr;
   assign bus1.read_request_i = rd;
   assign bus1.write_data_i = wdata;
   assign bus1.write_strobe_i = strb;
   assign bus1.write_request_i = wr;

   sys_timer #(.PRESCALE(4)) dut4 (.clock_i(clk), .reset_i(rst_n), .bus(bus4));
   sys_timer #(.PRESCALE(1)) dut1 (.clock_i(clk), .reset_i(rst_n), .bus(bus1));

   // Reference model state, one entry per instance
   int          pre [2] = '{4, 1};
   logic [63:0] m_time [2];
   logic [63:0] m_cmp [2];
   logic        m_en [2];
   int          m_phase [2];
   logic [31:0] m_rdata [2];
   logic        m_rresp [2];
   logic        m_wresp [2];
   logic        m_irq [2];

   function automatic logic [31:0] bytes_merge(logic [31:0] o, logic [31:0] n, logic [3:0] s);
      logic [31:0] r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] reg_val(int i, logic [2:0] s);
      case (s)
         3'd0: return {31'd0, m_en[i]};
         3'd1: return m_time[i][31:0];
         3'd2: return m_time[i][63:32];
         3'd3: return m_cmp[i][31:0];
         3'd4: return m_cmp[i][63:32];
         default: return 32'd0;
      endcase
   endfunction

   // Outputs and state after the coming edge, given the inputs now applied
   function automatic void model_step(int i);
      logic [2:0]  s = addr[4:2];
      logic [63:0] t0 = m_time[i];
      logic [63:0] c0 = m_cmp[i];
      if (!rst_n) begin
         m_time[i] = 64'd0; m_cmp[i] = '1; m_en[i] = 1'b0; m_phase[i] = 0;
         m_rdata[i] = 32'd0; m_rresp[i] = 1'b0; m_wresp[i] = 1'b0; m_irq[i] = 1'b0;
         return;
      end
      m_rdata[i] = rd ? reg_val(i, s) : 32'd0;
      m_rresp[i] = rd;
      m_wresp[i] = wr;
      m_irq[i]   = m_en[i] && (t0 >= c0);
      if (m_en[i]) begin
         m_phase[i] = (m_phase[i] + 1) % pre[i];
         if (m_phase[i] == 0) m_time[i] = t0 + 64'd1;
      end
      if (wr) begin
         case (s)
            3'd0: begin
               if (strb[0]) m_en[i] = wdata[0];
               m_phase[i] = 0;
            end
            3'd1: m_time[i] = {t0[63:32], bytes_merge(t0[31:0], wdata, strb)};
            3'd2: m_time[i] = {bytes_merge(t0[63:32], wdata, strb), t0[31:0]};
            3'd3: m_cmp[i] = {c0[63:32], bytes_merge(c0[31:0], wdata, strb)};
            3'd4: m_cmp[i] = {bytes_merge(c0[63:32], wdata, strb), c0[31:0]};
            default: ;
         endcase
      end
   endfunction

   function automatic logic [31:0] obs_rdata(int i);
      return (i == 0) ? bus4.read_data_o : bus1.read_data_o;
   endfunction
   function automatic logic obs_rresp(int i);
      return (i == 0) ? bus4.read_response_o : bus1.read_response_o;
   endfunction
   function automatic logic obs_wresp(int i);
      return (i == 0) ? bus4.write_response_o : bus1.write_response_o;
   endfunction
   function automatic logic obs_irq(int i);
      return (i == 0) ? bus4.irq_o : bus1.irq_o;
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
   endtask

   // One clock with the inputs currently applied, outputs compared to the model
   task automatic cycle();
      for (int i = 0; i < 2; i++) model_step(i);
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rdata[P%0d]", pre[i]), 64'(obs_rdata(i)), 64'(m_rdata[i]));
         check($sformatf("rresp[P%0d]", pre[i]), 64'(obs_rresp(i)), 64'(m_rresp[i]));
         check($sformatf("wresp[P%0d]", pre[i]), 64'(obs_wresp(i)), 64'(m_wresp[i]));
         check($sformatf("irq[P%0d]", pre[i]), 64'(obs_irq(i)), 64'(m_irq[i]));
      end
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic do_write(logic [31:0] a, logic [31:0] d, logic [3:0] s);
      addr = a; wdata = d; strb = s; wr = 1'b1;
      cycle();
      wr = 1'b0;
   endtask

   task automatic do_read(logic [31:0] a);
      addr = a; rd = 1'b1;
      cycle();
      rd = 1'b0;
   endtask

   task automatic do_reset(int n);
      rst_n = 1'b0;
      idle(n);
      rst_n = 1'b1;
   endtask

   initial begin
      logic        seen;
      logic [31:0] v;

      // Reset and reset value of MTIMECMP_HI
      do_reset(3);
      check("irq_after_reset", 64'(bus4.irq_o | bus1.irq_o), 64'd0);
      check("rdata_after_reset", 64'(bus4.read_data_o), 64'd0);
      do_read(32'h10);
      check("cmp_hi_reset_p4", 64'(bus4.read_data_o), 64'hFFFF_FFFF);
      check("cmp_hi_reset_p1", 64'(bus1.read_data_o), 64'hFFFF_FFFF);
      idle(1);
      check("rresp_one_cycle", 64'(bus4.read_response_o), 64'd0);
      check("rdata_cleared", 64'(bus4.read_data_o), 64'd0);

      // Byte strobes on MTIMECMP_LO
      do_write(32'h0C, 32'hAABB_CCDD, 4'b0101);
      check("wresp_pulse", 64'(bus4.write_response_o), 64'd1);
      idle(1);
      check("wresp_one_cycle", 64'(bus4.write_response_o), 64'd0);
      do_read(32'h0C);
      check("strobe_merge", 64'(bus4.read_data_o), 64'hFFBB_FFDD);

      // Counting with PRESCALE=4, then hold with EN=0
      do_reset(1);
      do_write(32'h0, 32'h1, 4'hF);
      idle(40);
      do_read(32'h4);
      v = bus4.read_data_o;
      check("count40_p4_in_range", 64'((v >= 32'd9) && (v <= 32'd11)), 64'd1);
      do_write(32'h0, 32'h0, 4'hF);
      idle(20);
      do_read(32'h4);
      check("hold_p4", 64'(bus4.read_data_o), 64'(m_time[0][31:0]));
      check("hold_p4_in_range", 64'((bus4.read_data_o >= 32'd9) && (bus4.read_data_o <= 32'd12)),
            64'd1);

      // Interrupt on the PRESCALE=1 instance
      do_reset(2);
      do_write(32'h0C, 32'd5, 4'hF);
      do_write(32'h10, 32'd0, 4'hF);
      do_write(32'h0, 32'h1, 4'hF);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         cycle();
         seen = bus1.irq_o;
      end
      check("irq_rises_p1", 64'(seen), 64'd1);
      do_write(32'h0C, 32'd100, 4'hF);
      idle(1);
      check("irq_falls_p1", 64'(bus1.irq_o), 64'd0);

      // mtime wrap and write/increment collision
      do_reset(1);
      do_write(32'h8, 32'hFFFF_FFFF, 4'hF);
      do_write(32'h4, 32'hFFFF_FFFF, 4'hF);
      do_write(32'h0, 32'h1, 4'hF);
      idle(6);
      do_read(32'h8);
      check("wrap_hi_p4", 64'(bus4.read_data_o), 64'd0);
      check("wrap_hi_p1", 64'(bus1.read_data_o), 64'd0);
      do_write(32'h4, 32'd7, 4'hF);
      do_read(32'h4);
      check("collision_p1", 64'(bus1.read_data_o), 64'd7);
      check("collision_p4", 64'(bus4.read_data_o), 64'd7);

      // Simultaneous read+write to reserved offset, then back-to-back reads
      addr = 32'h1C; wdata = 32'h1234_5678; strb = 4'hF; rd = 1'b1; wr = 1'b1;
      cycle();
      rd = 1'b0; wr = 1'b0;
      check("reserved_read", 64'(bus4.read_data_o), 64'd0);
      check("both_resp", 64'({bus4.read_response_o, bus4.write_response_o}), 64'd3);
      rd = 1'b1; addr = 32'h4;
      cycle();
      check("b2b_first", 64'(bus1.read_response_o), 64'd1);
      addr = 32'h8;
      cycle();
      rd = 1'b0;
      check("b2b_second", 64'(bus1.read_response_o), 64'd1);
      check("b2b_hi_p1", 64'(bus1.read_data_o), 64'd0);

      // Randomized traffic, including occasional reset mid-transaction
      for (int k = 0; k < 600; k++) begin
         rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         rd    = ($urandom_range(0, 2) == 0);
         wr    = ($urandom_range(0, 3) == 0);
         addr  = $urandom;
         strb  = 4'($urandom);
         wdata = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 64);
         cycle();
      end
      rd = 1'b0; wr = 1'b0; rst_n = 1'b1;
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
